// File: rtl/apb_pkg.sv
// Shared FSM state encoding and default parameter values for the APB decode manager.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb_state_e;

   localparam int unsigned     DEF_DATA_WIDTH     = 32;
   localparam int unsigned     DEF_ADDR_WIDTH     = 32;
   localparam int unsigned     DEF_PROT_WIDTH     = 3;
   localparam int unsigned     DEF_PRPH_NUM       = 4;
   localparam logic [31:0]     DEF_BASE_ADDR      = 32'h4000_0000;
   localparam int unsigned     DEF_REGION_BITS    = 12;
   localparam int unsigned     DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps an address into a one-hot subordinate select plus a miss flag.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int unsigned          AddrWidth  = DEF_ADDR_WIDTH,
   parameter int unsigned          PrphNum    = DEF_PRPH_NUM,
   parameter logic [AddrWidth-1:0] BaseAddr   = AddrWidth'(DEF_BASE_ADDR),
   parameter int unsigned          RegionBits = DEF_REGION_BITS
) (
   input  logic [AddrWidth-1:0] i_addr,
   output logic [PrphNum-1:0]   o_sel,
   output logic                 o_miss
);

   logic [AddrWidth-1:0] w_offset;
   logic [AddrWidth-1:0] w_index;

   assign w_offset = i_addr - BaseAddr;
   assign w_index  = w_offset >> RegionBits;

   always_comb begin
      o_miss = (i_addr < BaseAddr) || (w_index >= AddrWidth'(PrphNum));
      o_sel  = '0;
      for (int unsigned i = 0; i < PrphNum; i++) begin
         o_sel[i] = !o_miss && (w_index == AddrWidth'(i));
      end
   end

endmodule

// File: rtl/apb_decode_manager.sv
// APB requester: accepts a single-cycle request, decodes the target subordinate and runs
// the SETUP/ACCESS handshake with a bounded wait, reporting completion through a done pulse.
module apb_decode_manager
   import apb_pkg::*;
#(
   parameter int unsigned          DataWidth     = DEF_DATA_WIDTH,
   parameter int unsigned          AddrWidth     = DEF_ADDR_WIDTH,
   parameter int unsigned          ProtWidth     = DEF_PROT_WIDTH,
   parameter int unsigned          PrphNum       = DEF_PRPH_NUM,
   parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(DEF_BASE_ADDR),
   parameter int unsigned          RegionBits    = DEF_REGION_BITS,
   parameter int unsigned          TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mgr_wEn,
   input  logic                   mgr_rEn,
   input  logic [AddrWidth-1:0]   mgr_addr,
   input  logic [DataWidth-1:0]   mgr_wData,
   input  logic [DataWidth/8-1:0] mgr_wStrb,
   input  logic [ProtWidth-1:0]   mgr_prot,
   output logic [DataWidth-1:0]   mgr_rData,
   output logic                   mgr_error,
   output logic                   mgr_busy,
   output logic                   mgr_done,
   input  logic                   bus_ready,
   input  logic                   bus_subError,
   input  logic [DataWidth-1:0]   bus_rData,
   output logic [PrphNum-1:0]     bus_selectors,
   output logic                   bus_enable,
   output logic                   bus_write,
   output logic [AddrWidth-1:0]   bus_addr,
   output logic [DataWidth-1:0]   bus_wData,
   output logic [DataWidth/8-1:0] bus_strb,
   output logic [ProtWidth-1:0]   bus_prot
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned WaitWidth = $clog2(TimeoutCycles + 1);

   apb_state_e             r_state;
   apb_state_e             w_state_nxt;
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_wdata;
   logic [StrbWidth-1:0]   r_strb;
   logic [ProtWidth-1:0]   r_prot;
   logic                   r_write;
   logic [PrphNum-1:0]     r_sel;
   logic [WaitWidth-1:0]   r_wait;
   logic [DataWidth-1:0]   r_rdata;
   logic                   r_error;

   logic [PrphNum-1:0]     w_dec_sel;
   logic                   w_dec_miss;
   logic                   w_accept;
   logic                   w_reject;
   logic                   w_complete;
   logic                   w_timeout;
   logic                   w_active;
   logic                   w_is_write;

   apb_addr_decode #(
      .AddrWidth  (AddrWidth),
      .PrphNum    (PrphNum),
      .BaseAddr   (BaseAddr),
      .RegionBits (RegionBits)
   ) u_decode (
      .i_addr (mgr_addr),
      .o_sel  (w_dec_sel),
      .o_miss (w_dec_miss)
   );

   assign w_is_write = mgr_wEn && !mgr_rEn;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mgr_wEn || mgr_rEn) begin
               w_accept = 1'b1;
               if (w_dec_miss || (mgr_wEn && mgr_rEn)) begin
                  w_reject    = 1'b1;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_SETUP;
               end
            end
         end
         ST_SETUP:  w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            // Ready is checked first so a late ready still completes on the timeout cycle.
            if (bus_ready) begin
               w_complete  = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (r_wait == WaitWidth'(TimeoutCycles)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase

      w_active      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
      mgr_busy      = w_active;
      mgr_done      = (r_state == ST_RESP);
      mgr_rData     = r_rdata;
      mgr_error     = r_error;
      bus_enable    = (r_state == ST_ACCESS);
      bus_selectors = w_active ? r_sel   : '0;
      bus_write     = w_active ? r_write : 1'b0;
      bus_addr      = w_active ? r_addr  : '0;
      bus_wData     = w_active ? r_wdata : '0;
      bus_strb      = w_active ? r_strb  : '0;
      bus_prot      = w_active ? r_prot  : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_prot  <= '0;
         r_write <= 1'b0;
         r_sel   <= '0;
         r_wait  <= '0;
         r_rdata <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr  <= mgr_addr;
            r_write <= w_is_write;
            r_wdata <= w_is_write ? mgr_wData : '0;
            r_strb  <= w_is_write ? mgr_wStrb : '0;
            r_prot  <= mgr_prot;
            r_sel   <= w_dec_sel;
            r_wait  <= '0;
         end
         if (w_reject) begin
            r_error <= 1'b1;
         end
         if (w_complete) begin
            r_error <= bus_subError;
            if (!r_write) begin
               r_rdata <= bus_rData;
            end
         end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= '0;
         end else if (r_state == ST_ACCESS) begin
            r_wait <= r_wait + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_decode_manager.sv
// Table-driven scoreboard bench for apb_decode_manager with a reactive APB subordinate model.
module tb_apb_decode_manager;

   logic        clk = 1'b0;
   logic        reset;
   logic        mgr_wEn, mgr_rEn;
   logic [31:0] mgr_addr, mgr_wData;
   logic [3:0]  mgr_wStrb;
   logic [2:0]  mgr_prot;
   logic [31:0] mgr_rData;
   logic        mgr_error, mgr_busy, mgr_done;
   logic        bus_ready, bus_subError;
   logic [31:0] bus_rData;
   logic [3:0]  bus_selectors;
   logic        bus_enable, bus_write;
   logic [31:0] bus_addr, bus_wData;
   logic [3:0]  bus_strb;
   logic [2:0]  bus_prot;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apb_decode_manager #(
      .DataWidth     (32),
      .AddrWidth     (32),
      .ProtWidth     (3),
      .PrphNum       (4),
      .BaseAddr      (32'h4000_0000),
      .RegionBits    (12),
      .TimeoutCycles (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mgr_wEn       (mgr_wEn),
      .mgr_rEn       (mgr_rEn),
      .mgr_addr      (mgr_addr),
      .mgr_wData     (mgr_wData),
      .mgr_wStrb     (mgr_wStrb),
      .mgr_prot      (mgr_prot),
      .mgr_rData     (mgr_rData),
      .mgr_error     (mgr_error),
      .mgr_busy      (mgr_busy),
      .mgr_done      (mgr_done),
      .bus_ready     (bus_ready),
      .bus_subError  (bus_subError),
      .bus_rData     (bus_rData),
      .bus_selectors (bus_selectors),
      .bus_enable    (bus_enable),
      .bus_write     (bus_write),
      .bus_addr      (bus_addr),
      .bus_wData     (bus_wData),
      .bus_strb      (bus_strb),
      .bus_prot      (bus_prot)
   );

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;    // ready-low ACCESS cycles before ready; -1 = never
      logic        suberr;
      logic [31:0] rdata;
      logic [3:0]  exp_sel;
      int          exp_lat;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[9];
   vec_t sb[$];

   function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                               input logic suberr, input logic [31:0] rdata, input logic [3:0] exp_sel,
                               input int exp_lat, input logic exp_err, input logic chk_rd,
                               input logic [31:0] exp_rd);
      vec_t v;
      v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.waits = waits; v.suberr = suberr; v.rdata = rdata; v.exp_sel = exp_sel;
      v.exp_lat = exp_lat; v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({mgr_rData, mgr_error, mgr_busy, mgr_done, bus_selectors, bus_enable,
                   bus_write, bus_addr, bus_wData, bus_strb, bus_prot});
   endfunction

   task automatic do_xfer(input vec_t v, input string tag);
      vec_t e;
      int   lat = 0, acc = 0, first_en = 0, busy_cnt = 0;
      logic done = 1'b0, stable = 1'b1, valid;
      logic [3:0] seen_sel = '0;
      logic [31:0] s_addr = '0;
      @(posedge clk); #1;
      mgr_wEn = v.we; mgr_rEn = v.re; mgr_addr = v.addr;
      mgr_wData = v.wdata; mgr_wStrb = v.strb; mgr_prot = 3'd5;
      sb.push_back(v);
      valid = (v.exp_sel != 4'b0000);
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk); #1;
         mgr_wEn = 1'b0; mgr_rEn = 1'b0;
         mgr_addr = 32'hFFFF_FFFF; mgr_wData = 32'h5555_5555; mgr_wStrb = 4'h0;
         lat++;
         bus_rData    = v.rdata;
         bus_subError = v.suberr;
         bus_ready    = bus_enable && (v.waits >= 0) && (acc == v.waits);
         if (bus_enable) begin
            acc++;
            if (first_en == 0) first_en = lat;
            if (bus_addr !== s_addr || bus_selectors !== v.exp_sel) stable = 1'b0;
         end
         if (mgr_busy) busy_cnt++;
         seen_sel |= bus_selectors;
         if (lat == 1 && valid) begin
            s_addr = bus_addr;
            chk({tag, " setup_addr"},  128'(bus_addr),   128'(v.addr));
            chk({tag, " setup_wr"},    128'(bus_write),  128'(v.we));
            chk({tag, " setup_wdata"}, 128'(bus_wData),  128'(v.we ? v.wdata : 32'h0));
            chk({tag, " setup_strb"},  128'(bus_strb),   128'(v.we ? v.strb : 4'h0));
            chk({tag, " setup_prot"},  128'(bus_prot),   128'(3'd5));
            chk({tag, " setup_en"},    128'(bus_enable), 128'(1'b0));
         end
         if (mgr_done) done = 1'b1;
      end
      bus_ready = 1'b0; bus_subError = 1'b0;
      e = sb.pop_front();
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s done_timeout: no done within 40 cycles, expected at %0d", tag, e.exp_lat);
      end else begin
         chk({tag, " latency"}, 128'(lat),       128'(e.exp_lat));
         chk({tag, " error"},   128'(mgr_error), 128'(e.exp_err));
         chk({tag, " sel"},     128'(seen_sel),  128'(e.exp_sel));
         chk({tag, " busy"},    128'(busy_cnt),  128'(valid ? e.exp_lat - 1 : 0));
         chk({tag, " enable_outs_in_resp"}, 128'({bus_selectors, bus_enable, mgr_busy}), 128'(0));
         if (valid) begin
            chk({tag, " en_at"},  128'(first_en), 128'(2));
            chk({tag, " stable"}, 128'(stable),   128'(1'b1));
         end
         if (e.chk_rd) chk({tag, " rdata"}, 128'(mgr_rData), 128'(e.exp_rd));
      end
   endtask

   initial begin
      int   done_cnt, busy_cnt;
      logic got_en;
      reset = 1'b1;
      mgr_wEn = 1'b0; mgr_rEn = 1'b0; mgr_addr = '0; mgr_wData = '0; mgr_wStrb = '0; mgr_prot = '0;
      bus_ready = 1'b0; bus_subError = 1'b0; bus_rData = '0;

      //          we    re    addr            wdata          strb  wt  se    rdata          sel      lat err   chk   exp_rd
      vecs[0] = mk(1'b1, 1'b0, 32'h4000_1008, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,         4'b0010, 3, 1'b0, 1'b1, 32'h0);
      vecs[1] = mk(1'b0, 1'b1, 32'h4000_3000, 32'h0,         4'h0, 3, 1'b0, 32'h1234_5678, 4'b1000, 6, 1'b0, 1'b1, 32'h1234_5678);
      vecs[2] = mk(1'b0, 1'b1, 32'h4000_4000, 32'h0,         4'h0, 0, 1'b0, 32'h0,         4'b0000, 1, 1'b1, 1'b0, 32'h0);
      vecs[3] = mk(1'b0, 1'b1, 32'h3FFF_FFFC, 32'h0,         4'h0, 0, 1'b0, 32'h0,         4'b0000, 1, 1'b1, 1'b0, 32'h0);
      vecs[4] = mk(1'b1, 1'b1, 32'h4000_0000, 32'h1111_2222, 4'hF, 0, 1'b0, 32'h0,         4'b0000, 1, 1'b1, 1'b0, 32'h0);
      vecs[5] = mk(1'b1, 1'b0, 32'h4000_2000, 32'h7777_8888, 4'hC, -1, 1'b0, 32'hFFFF_0000, 4'b0100, 19, 1'b1, 1'b1, 32'h0);
      vecs[6] = mk(1'b0, 1'b1, 32'h4000_0004, 32'h0,         4'h0, 0, 1'b1, 32'hA5A5_0001, 4'b0001, 3, 1'b1, 1'b1, 32'hA5A5_0001);
      vecs[7] = mk(1'b1, 1'b0, 32'h4000_3FFC, 32'h0BAD_F00D, 4'h3, 1, 1'b0, 32'h9999_9999, 4'b1000, 4, 1'b0, 1'b1, 32'hA5A5_0001);
      vecs[8] = mk(1'b0, 1'b1, 32'h4000_1000, 32'h0,         4'h0, 0, 1'b0, 32'hCAFE_F00D, 4'b0010, 3, 1'b0, 1'b1, 32'hCAFE_F00D);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 128'(0));
      reset = 1'b0;

      foreach (vecs[i]) do_xfer(vecs[i], $sformatf("vec%0d", i));

      // Reset raised mid-ACCESS, with a request presented during the reset cycle.
      @(posedge clk); #1;
      mgr_rEn = 1'b1; mgr_addr = 32'h4000_2000; mgr_prot = 3'd1;
      got_en = 1'b0;
      for (int c = 0; c < 10 && !got_en; c++) begin
         @(posedge clk); #1;
         mgr_rEn = 1'b0;
         if (bus_enable) got_en = 1'b1;
      end
      chk("rst_reached_access", 128'(got_en), 128'(1'b1));
      reset = 1'b1;
      mgr_wEn = 1'b1; mgr_addr = 32'h4000_0000; mgr_wData = 32'hFEED_FACE; mgr_wStrb = 4'hF;
      @(posedge clk); #1;
      reset = 1'b0;
      mgr_wEn = 1'b0;
      chk("rst_midflight_outputs", all_outs(), 128'(0));
      done_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (mgr_done) done_cnt++;
         if (mgr_busy) busy_cnt++;
         @(posedge clk); #1;
      end
      chk("rst_no_done", 128'(done_cnt), 128'(0));
      chk("rst_no_accept", 128'(busy_cnt), 128'(0));

      do_xfer(mk(1'b0, 1'b1, 32'h4000_2010, 32'h0, 4'h0, 2, 1'b0, 32'h0F0F_0F0F,
                 4'b0100, 5, 1'b0, 1'b1, 32'h0F0F_0F0F), "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
